raster_setup_seq: RTL
=====================

# raster_setup_seq

Per-line setup sequencer for the raster pipeline. It holds the per-frame triangle parameters in a double-buffered register bank that the vertex stage writes through a valid/ready port. It steps the per-line edge-function and barycentric start values with one shared adder during horizontal blanking. It presents the line-start values to the raster so they are stable when the raster latches them at x==799.

## Interface
Parameters:
- HACT, 640, visible pixels per line
- VACT, 480, visible lines
- VTOTAL, 525, total lines per frame
- NCH, 18, configuration channels (10 stepped, 8 static)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset. Asynchronous, active-low.
- x, y  in  10 each  VGA counters
- cfg_valid  in  1  config word valid
- cfg_ready  out  1  config word accepted when high with cfg_valid
- cfg_sel  in  5  channel index
- cfg_init  in  22  line-0 value (edge channels use [19:0])
- cfg_step  in  22  per-line increment; ignored for static channels
- cfg_commit  in  1  word closes the frame set and marks the shadow bank for swap
- e_init  out  120  {e2_t2,e1_t2,e0_t2,e2_t1,e1_t1,e0_t1}, 20 bits each
- bar_init  out  88  {bar2_iz,bar2_iy,bar_iz,bar_iy}, 22 bits each
- bar_dx  out  88  {bar2_iz_dx,bar2_iy_dx,bar_iz_dx,bar_iy_dx}
- y_screen  out  80  {v3,v2,v1,v0}, 20 bits each
- line_ready  out  1  high when stepping is complete
- frame_swapped  out  1  one-cycle pulse on a bank swap

## Operation
- **Channel map:**
  - 0-5: e0..e2_t1, e0..e2_t2
  - 6-9: bar_iy, bar_iz, bar2_iy, bar2_iz
  - 10-13: the four dx values
  - 14-17: y_screen_v0..v3
  - cfg_sel > 17 is accepted and dropped.
- **Banks:**
  - Shadow bank: init and step per channel.
  - Active bank: init and step per channel.
  - Line registers L[0..9].
  - Static outputs come from active init[10..17].
- **Config handshake:**
  - A write lands in the shadow bank on cfg_valid && cfg_ready.
  - cfg_commit on an accepted word sets commit_pending.
  - Writes after a commit, before the swap, join the pending set.
- **Frame start**, at (y==VTOTAL-1, x==0):
  - If commit_pending: active ← shadow, pending cleared, frame_swapped pulses.
  - In the same cycle, L[c] ← init[c] (new active bank if swapped) for all c.
  - Without a commit, L reloads from the unchanged active bank.
- **Line step:**
  - FSM states: IDLE and STEP.
  - IDLE → STEP when x==HACT && y<VACT-1.
  - In STEP, channel counter k = 0..9, one per cycle: L[k] ← L[k] + step[k].
  - After k==9 the FSM returns to IDLE.
  - line_ready = (state==IDLE).
- **Arithmetic:**
  - Channels 0-5 wrap modulo 2^20 using step[19:0].
  - Channels 6-9 wrap modulo 2^22.
  - Two's complement, no saturation.
- Exact-compare triggers only. An x/y value that skips the trigger point causes no step or reload.

## Timing
- **Reset:**
  - All banks, L, and outputs = 0; commit_pending = 0; FSM in IDLE.
  - cfg_ready = 1, line_ready = 1, frame_swapped = 0.
- **Step window:**
  - STEP occupies x = 640..649 of line y.
  - Outputs hold line-(y+1) values from x==650 until x==639 of the next line, which covers the raster's x==799 latch.
- **Line 0 values** are valid from (524, 1), ahead of the (524, 799) latch.
- **Line VACT-1** has no step. Vblank lines hold their values until the reload.
- **Swap cycle:** cfg_ready = 0 for exactly the (524, 0) cycle.
  - A commit presented then is held by the requester and applies at the next frame.
- Output updates are registered. e_init/bar_init change one cycle after the corresponding k cycle.
- **Reset mid-STEP:** immediate clear with no partial writeback. After rst_n rises the FSM waits for the next trigger.

## Structure
- Package raster_pkg holds:
  - VGA timing constants.
  - Channel index localparams (CH_E0_T1..CH_YS_V3).
  - Widths W_E=20 and W_B=22.
- Sub-module raster_param_bank holds the shadow/active register file with swap. It has one write port and parallel read of the active bank.
- The sequencer FSM, the shared adder, and L live in raster_setup_seq.

## Test plan
- Reset held, random x/y → all outputs 0, cfg_ready=1, line_ready=1, no frame_swapped.
- Ch0 init=100, step=-3, commit; run a full frame:
  - e_init[19:0]=100 at (524, 799).
  - 97 at (0, 799).
  - 100-3·479 = -1337 at (478, 799).
  - Holds through vblank.
- Ch6 init=0x1FFFFF, step=1 → bar_init[21:0]=0x200000 after line 0. Ch0 init=0x7FFFF, step=1 → 0x80000.
- Commit presented at (524, 0) → cfg_ready low, old bank used for this frame. Commit accepted at (524, 1), swap pulse at the following frame start.
- No new commit across two frames → identical L sequence each frame, frame_swapped never pulses. Ch14 write without commit does not reach y_screen.
- rst_n asserted at (10, 645) → outputs 0 within the same cycle. After release, line_ready=1 and no step until x==640 of the next line.

Source files
------------

// File: rtl/raster_setup_seq_pkg.sv
// Shared constants for the raster setup sequencer: VGA timing, channel map,
// datapath widths and the FSM state type.
package raster_pkg;

  localparam int H_ACT   = 640;
  localparam int V_ACT   = 480;
  localparam int V_TOTAL = 525;
  localparam int N_CHAN  = 18;
  localparam int NSTEP   = 10;

  localparam int W_E   = 20;
  localparam int W_B   = 22;
  localparam int W_SEL = 5;

  localparam int CH_E0_T1      = 0;
  localparam int CH_E1_T1      = 1;
  localparam int CH_E2_T1      = 2;
  localparam int CH_E0_T2      = 3;
  localparam int CH_E1_T2      = 4;
  localparam int CH_E2_T2      = 5;
  localparam int CH_BAR_IY     = 6;
  localparam int CH_BAR_IZ     = 7;
  localparam int CH_BAR2_IY    = 8;
  localparam int CH_BAR2_IZ    = 9;
  localparam int CH_BAR_IY_DX  = 10;
  localparam int CH_BAR_IZ_DX  = 11;
  localparam int CH_BAR2_IY_DX = 12;
  localparam int CH_BAR2_IZ_DX = 13;
  localparam int CH_YS_V0      = 14;
  localparam int CH_YS_V1      = 15;
  localparam int CH_YS_V2      = 16;
  localparam int CH_YS_V3      = 17;

  typedef enum logic {
    ST_IDLE,
    ST_STEP
  } seq_state_e;

  // Edge channels live in 20 bits; keeping the top bits zero makes them wrap at 2^20.
  function automatic logic [W_B-1:0] wrap_chan(input logic [3:0] ch, input logic [W_B-1:0] v);
    return (ch < 4'(CH_BAR_IY)) ? {{(W_B-W_E){1'b0}}, v[W_E-1:0]} : v;
  endfunction

endpackage

// File: rtl/raster_setup_seq_if.sv
// Configuration write port from the vertex stage into the setup sequencer.
interface raster_setup_seq_if
  import raster_pkg::*;
;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [W_SEL-1:0] cfg_sel;
  logic [W_B-1:0]   cfg_init;
  logic [W_B-1:0]   cfg_step;
  logic             cfg_commit;

  modport master (
    output cfg_valid, cfg_sel, cfg_init, cfg_step, cfg_commit,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_sel, cfg_init, cfg_step, cfg_commit,
    output cfg_ready
  );
endinterface

// File: rtl/raster_setup_seq_param_bank.sv
// Shadow/active parameter register file: one write port into the shadow bank,
// whole-bank copy to active on swap, parallel read of the active bank.
module raster_param_bank
  import raster_pkg::*;
#(
  parameter int NCH = N_CHAN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we_i,
  input  logic [W_SEL-1:0]        sel_i,
  input  logic [W_B-1:0]          init_i,
  input  logic [W_B-1:0]          step_i,
  input  logic                    swap_i,
  output logic [NCH-1:0][W_B-1:0] act_init_o,
  output logic [NCH-1:0][W_B-1:0] act_step_o,
  output logic [NCH-1:0][W_B-1:0] nxt_init_o
);

  logic [NCH-1:0][W_B-1:0] sh_init_q;
  logic [NCH-1:0][W_B-1:0] sh_step_q;
  logic [NCH-1:0][W_B-1:0] act_init_q;
  logic [NCH-1:0][W_B-1:0] act_step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_init_q  <= '0;
      sh_step_q  <= '0;
      act_init_q <= '0;
      act_step_q <= '0;
    end else begin
      if (we_i && (int'(sel_i) < NCH)) begin
        sh_init_q[sel_i] <= init_i;
        sh_step_q[sel_i] <= step_i;
      end
      if (swap_i) begin
        act_init_q <= sh_init_q;
        act_step_q <= sh_step_q;
      end
    end
  end

  assign act_init_o = act_init_q;
  assign act_step_o = act_step_q;
  // Lets the line registers load the incoming bank in the same cycle as the swap.
  assign nxt_init_o = swap_i ? sh_init_q : act_init_q;

endmodule

// File: rtl/raster_setup_seq.sv
// Per-line setup sequencer: reloads line-start values at frame start and steps
// the ten stepped channels through one shared adder during horizontal blanking.
module raster_setup_seq
  import raster_pkg::*;
#(
  parameter int HACT   = H_ACT,
  parameter int VACT   = V_ACT,
  parameter int VTOTAL = V_TOTAL,
  parameter int NCH    = N_CHAN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [9:0]               x,
  input  logic [9:0]               y,
  raster_setup_seq_if.slave        cfg,
  output logic [6*W_E-1:0]         e_init,
  output logic [4*W_B-1:0]         bar_init,
  output logic [4*W_B-1:0]         bar_dx,
  output logic [4*W_E-1:0]         y_screen,
  output logic                     line_ready,
  output logic                     frame_swapped
);

  localparam logic [9:0] X_STEP      = 10'(HACT);
  localparam logic [9:0] Y_STEP_LIM  = 10'(VACT - 1);
  localparam logic [9:0] Y_FRAME     = 10'(VTOTAL - 1);

  logic frame_start;
  logic step_trig;
  logic accept;
  logic swap;

  logic commit_pending_q, commit_pending_d;
  logic frame_swapped_q;

  seq_state_e state_q, state_d;
  logic [3:0] k_q, k_d;
  logic       do_step;
  logic [3:0] cur_k;
  logic [W_B-1:0] sum;

  logic [NSTEP-1:0][W_B-1:0] line_q, line_d;
  logic [NSTEP-1:0][W_B-1:0] step_vec;

  logic [NCH-1:0][W_B-1:0] act_init;
  logic [NCH-1:0][W_B-1:0] act_step;
  logic [NCH-1:0][W_B-1:0] nxt_init;

  assign frame_start   = (y == Y_FRAME) && (x == '0);
  assign step_trig     = (x == X_STEP) && (y < Y_STEP_LIM);
  assign cfg.cfg_ready = !frame_start;
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign swap          = frame_start && commit_pending_q;

  raster_param_bank #(.NCH(NCH)) u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (accept),
    .sel_i      (cfg.cfg_sel),
    .init_i     (cfg.cfg_init),
    .step_i     (cfg.cfg_step),
    .swap_i     (swap),
    .act_init_o (act_init),
    .act_step_o (act_step),
    .nxt_init_o (nxt_init)
  );

  // Writes can never land in the swap cycle because cfg_ready is low there.
  always_comb begin
    commit_pending_d = commit_pending_q;
    if (swap) begin
      commit_pending_d = 1'b0;
    end
    if (accept && cfg.cfg_commit) begin
      commit_pending_d = 1'b1;
    end
  end

  // The trigger cycle itself performs channel 0, so stepping covers x = HACT..HACT+9.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    do_step = 1'b0;
    cur_k   = k_q;
    case (state_q)
      ST_IDLE: begin
        if (step_trig) begin
          do_step = 1'b1;
          cur_k   = '0;
          k_d     = 4'd1;
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        do_step = 1'b1;
        k_d     = k_q + 4'd1;
        if (k_q == 4'(NSTEP - 1)) begin
          k_d     = '0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign step_vec = act_step[NSTEP-1:0];
  assign sum      = line_q[cur_k] + step_vec[cur_k];

  always_comb begin
    line_d = line_q;
    if (frame_start) begin
      for (int c = 0; c < NSTEP; c++) begin
        line_d[c] = wrap_chan(4'(c), nxt_init[c]);
      end
    end else if (do_step) begin
      line_d[cur_k] = wrap_chan(cur_k, sum);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      k_q              <= '0;
      line_q           <= '0;
      commit_pending_q <= 1'b0;
      frame_swapped_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      k_q              <= k_d;
      line_q           <= line_d;
      commit_pending_q <= commit_pending_d;
      frame_swapped_q  <= swap;
    end
  end

  always_comb begin
    e_init   = '0;
    bar_init = '0;
    bar_dx   = '0;
    y_screen = '0;
    for (int i = 0; i < 6; i++) begin
      e_init[i*W_E +: W_E] = line_q[CH_E0_T1+i][W_E-1:0];
    end
    for (int i = 0; i < 4; i++) begin
      bar_init[i*W_B +: W_B] = line_q[CH_BAR_IY+i];
      bar_dx[i*W_B +: W_B]   = act_init[CH_BAR_IY_DX+i];
      y_screen[i*W_E +: W_E] = act_init[CH_YS_V0+i][W_E-1:0];
    end
  end

  assign line_ready    = (state_q == ST_IDLE);
  assign frame_swapped = frame_swapped_q;

  logic unused_bits;
  assign unused_bits = ^{act_step, act_init, nxt_init, line_q};

endmodule
